byte_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 8-input byte priority-mux cell.
- Shares one byte lane between 8 requesters (A..H). It grants one requester at a time and drives the mux select bits so that the granted byte reaches the output.
- Presents the lane to a single consumer through a valid/ready handshake, with bounded bursts per grant.

---
 rtl/byte_mux_arbiter.sv | 143 ++++++++++++++
 tb/tb_byte_mux_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mux_arbiter.sv
// byte_mux_arbiter
//   Round-robin arbiter/sequencer sharing one byte lane among 8 requesters
//   (A..H) of the 8-input byte priority-mux cell. It grants one requester
//   at a time, drives the registered mux select bits, and hands words to a
//   single consumer over valid/ready with at most MaxBurst words per grant.
//
// Ports
//   Clk_i      rising-edge clock
//   Reset_n_i  synchronous active-low reset
//   Enable_i   allows new grants (a running burst is never aborted)
//   Req_i[7:0] level requests, bit0 = A ... bit7 = H
//   Ready_i    consumer accepts the word this cycle
//   Valid_o    lane holds a valid word from the granted requester
//   Ack_o[7:0] one-hot, word of requester g accepted this cycle
//   Grant_o    one-hot current grant, zero when idle
//   Busy_o     a grant is held
//   SAB_o..SH_o mux selects; grant g (1..7) raises exactly one, A raises none
module byte_mux_arbiter #(
  parameter int MaxBurst = 4
) (
  input  logic       Clk_i,
  input  logic       Reset_n_i,
  input  logic       Enable_i,
  input  logic [7:0] Req_i,
  input  logic       Ready_i,
  output logic       Valid_o,
  output logic [7:0] Ack_o,
  output logic [7:0] Grant_o,
  output logic       Busy_o,
  output logic       SAB_o,
  output logic       SC_o,
  output logic       SD_o,
  output logic       SE_o,
  output logic       SF_o,
  output logic       SG_o,
  output logic       SH_o
);

  // Width holds 0..MaxBurst, so the count can never wrap inside a grant.
  localparam int CW = $clog2(MaxBurst + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [7:0]      grant_q, grant_d;
  logic [2:0]      gidx_q,  gidx_d;
  logic [2:0]      last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [6:0]      sel_q,   sel_d;   // {SH,SG,SF,SE,SD,SC,SAB}

  logic            found;
  logic [2:0]      pick;
  logic [2:0]      cand;
  logic            valid;
  logic            xfer;
  logic [CW-1:0]   cnt_inc;

  // Round-robin search starting just after the last released requester;
  // the 8th candidate is Last itself, so it only wins when alone.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    for (int i = 1; i <= 8; i++) begin
      cand = last_q + 3'(i);
      if (!found && Req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Reset gates the lane outputs combinationally so they are quiet while
  // Reset_n_i is low, even before the registers clear.
  assign valid   = Reset_n_i && (state_q == BUSY) && Req_i[gidx_q];
  assign xfer    = valid && Ready_i;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (Enable_i && found) begin
          state_d = BUSY;
          grant_d = 8'b1 << pick;
          gidx_d  = pick;
          cnt_d   = '0;
          for (int g = 1; g < 8; g++) sel_d[g-1] = (pick == 3'(g));
        end
      end
      BUSY: begin
        // Request drop or a full burst both release; the released
        // requester becomes Last and so drops to lowest priority.
        if (!Req_i[gidx_q] || (xfer && cnt_inc == CW'(MaxBurst))) begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = '0;
          last_d  = gidx_q;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign Valid_o = valid;
  assign Ack_o   = xfer ? grant_q : 8'h00;
  assign Grant_o = grant_q;
  assign Busy_o  = (state_q == BUSY);
  assign SAB_o   = sel_q[0];
  assign SC_o    = sel_q[1];
  assign SD_o    = sel_q[2];
  assign SE_o    = sel_q[3];
  assign SF_o    = sel_q[4];
  assign SG_o    = sel_q[5];
  assign SH_o    = sel_q[6];

endmodule

// File: tb/tb_byte_mux_arbiter.sv
module tb_byte_mux_arbiter;
  logic       Clk_i = 1'b0;
  logic       Reset_n_i, Enable_i, Ready_i;
  logic [7:0] Req_i;
  logic       Valid_o, Busy_o;
  logic [7:0] Ack_o, Grant_o;
  logic       SAB_o, SC_o, SD_o, SE_o, SF_o, SG_o, SH_o;
  logic [6:0] sel;
  int         checks = 0;
  int         errors = 0;

  assign sel = {SH_o, SG_o, SF_o, SE_o, SD_o, SC_o, SAB_o};

  byte_mux_arbiter #(.MaxBurst(4)) dut (
    .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .Enable_i(Enable_i), .Req_i(Req_i),
    .Ready_i(Ready_i), .Valid_o(Valid_o), .Ack_o(Ack_o), .Grant_o(Grant_o),
    .Busy_o(Busy_o), .SAB_o(SAB_o), .SC_o(SC_o), .SD_o(SD_o), .SE_o(SE_o),
    .SF_o(SF_o), .SG_o(SG_o), .SH_o(SH_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Advance past the next rising edge; outputs are sampled 1-2 time units later.
  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic do_reset();
    Reset_n_i = 1'b0;
    tick();
    tick();
    Reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    Enable_i = 1'b1; Req_i = 8'hFF; Ready_i = 1'b1;
    Reset_n_i = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if (Grant_o !== 8'h00 || Busy_o !== 1'b0 || sel !== 7'h00) begin
      errors++;
      $display("FAIL reset_state: grant=%h busy=%b sel=%h, want 00/0/00", Grant_o, Busy_o, sel);
    end
    checks++;
    if (Valid_o !== 1'b0 || Ack_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_lane: valid=%b ack=%h, want 0/00", Valid_o, Ack_o);
    end
    Reset_n_i = 1'b1;
    Req_i = 8'h00;
  endtask

  task automatic test_single_burst();
    do_reset();
    Enable_i = 1'b1; Req_i = 8'h08; Ready_i = 1'b1;
    #1;
    checks++;
    if (Valid_o !== 1'b0 || Busy_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle: valid=%b busy=%b, want 0/0", Valid_o, Busy_o);
    end
    tick();
    checks++;
    if (Grant_o !== 8'h08 || SD_o !== 1'b1 || sel !== 7'h04 || Valid_o !== 1'b1 || Busy_o !== 1'b1) begin
      errors++;
      $display("FAIL t1_grant: grant=%h sel=%h valid=%b busy=%b, want 08/04/1/1", Grant_o, sel, Valid_o, Busy_o);
    end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      checks++;
      if (Ack_o !== 8'h08) begin
        errors++;
        $display("FAIL t1_ack%0d: ack=%h, want 08", j, Ack_o);
      end
    end
    tick();
    checks++;
    if (Grant_o !== 8'h00 || Busy_o !== 1'b0 || Valid_o !== 1'b0 || Ack_o !== 8'h00) begin
      errors++;
      $display("FAIL t1_bubble: grant=%h busy=%b valid=%b ack=%h, want 00/0/0/00", Grant_o, Busy_o, Valid_o, Ack_o);
    end
    tick();
    checks++;
    if (Grant_o !== 8'h08 || Ack_o !== 8'h08) begin
      errors++;
      $display("FAIL t1_regrant: grant=%h ack=%h, want 08/08", Grant_o, Ack_o);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] eg;
    logic [6:0] es;
    do_reset();
    Enable_i = 1'b1; Req_i = 8'hFF; Ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      eg = 8'h01 << (k % 8);
      es = eg[7:1];
      tick();
      checks++;
      if (Grant_o !== eg || sel !== es) begin
        errors++;
        $display("FAIL t2_grant%0d: grant=%h sel=%h, want %h/%h", k, Grant_o, sel, eg, es);
      end
      for (int j = 0; j < 4; j++) begin
        if (j > 0) tick();
        checks++;
        if (Ack_o !== eg) begin
          errors++;
          $display("FAIL t2_ack%0d_%0d: ack=%h, want %h", k, j, Ack_o, eg);
        end
      end
      tick();
      checks++;
      if (Busy_o !== 1'b0 || Grant_o !== 8'h00) begin
        errors++;
        $display("FAIL t2_bubble%0d: busy=%b grant=%h, want 0/00", k, Busy_o, Grant_o);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    Enable_i = 1'b1; Req_i = 8'h04; Ready_i = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (Valid_o !== 1'b1 || Ack_o !== 8'h00 || Grant_o !== 8'h04 || SC_o !== 1'b1) begin
        errors++;
        $display("FAIL t3_stall%0d: valid=%b ack=%h grant=%h sc=%b, want 1/00/04/1", i, Valid_o, Ack_o, Grant_o, SC_o);
      end
      tick();
    end
    Ready_i = 1'b1;
    #1;
    checks++;
    if (Ack_o !== 8'h04 || Grant_o !== 8'h04) begin
      errors++;
      $display("FAIL t3_release: ack=%h grant=%h, want 04/04", Ack_o, Grant_o);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    Enable_i = 1'b1; Req_i = 8'h10; Ready_i = 1'b1;
    tick();
    checks++;
    if (Grant_o !== 8'h10 || SE_o !== 1'b1 || Ack_o !== 8'h10) begin
      errors++;
      $display("FAIL t4_grant: grant=%h se=%b ack=%h, want 10/1/10", Grant_o, SE_o, Ack_o);
    end
    tick();
    checks++;
    if (Ack_o !== 8'h10) begin
      errors++;
      $display("FAIL t4_ack2: ack=%h, want 10", Ack_o);
    end
    tick();
    Req_i = 8'h01;
    #1;
    checks++;
    if (Valid_o !== 1'b0 || Ack_o !== 8'h00 || Grant_o !== 8'h10) begin
      errors++;
      $display("FAIL t4_drop: valid=%b ack=%h grant=%h, want 0/00/10", Valid_o, Ack_o, Grant_o);
    end
    tick();
    Req_i = 8'h11;
    #1;
    checks++;
    if (Busy_o !== 1'b0 || Grant_o !== 8'h00) begin
      errors++;
      $display("FAIL t4_idle: busy=%b grant=%h, want 0/00", Busy_o, Grant_o);
    end
    tick();
    checks++;
    if (Grant_o !== 8'h01 || sel !== 7'h00) begin
      errors++;
      $display("FAIL t4_wrap: grant=%h sel=%h, want 01/00", Grant_o, sel);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    Enable_i = 1'b1; Req_i = 8'h40; Ready_i = 1'b1;
    tick();
    checks++;
    if (Grant_o !== 8'h40 || SG_o !== 1'b1) begin
      errors++;
      $display("FAIL t5_grant: grant=%h sg=%b, want 40/1", Grant_o, SG_o);
    end
    tick();
    Reset_n_i = 1'b0;
    #1;
    checks++;
    if (Valid_o !== 1'b0 || Ack_o !== 8'h00) begin
      errors++;
      $display("FAIL t5_rst_lane: valid=%b ack=%h, want 0/00", Valid_o, Ack_o);
    end
    tick();
    checks++;
    if (Grant_o !== 8'h00 || Busy_o !== 1'b0 || SG_o !== 1'b0 || Valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t5_rst: grant=%h busy=%b sg=%b valid=%b, want 00/0/0/0", Grant_o, Busy_o, SG_o, Valid_o);
    end
    Reset_n_i = 1'b1;
    Req_i = 8'hC0;
    tick();
    checks++;
    if (Grant_o !== 8'h40 || SG_o !== 1'b1) begin
      errors++;
      $display("FAIL t5_regrant: grant=%h sg=%b, want 40/1", Grant_o, SG_o);
    end
  endtask

  task automatic test_enable();
    do_reset();
    Enable_i = 1'b0; Req_i = 8'h02; Ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Grant_o !== 8'h00 || Busy_o !== 1'b0) begin
        errors++;
        $display("FAIL t6_nogrant%0d: grant=%h busy=%b, want 00/0", i, Grant_o, Busy_o);
      end
    end
    Enable_i = 1'b1;
    tick();
    checks++;
    if (Grant_o !== 8'h02 || SAB_o !== 1'b1 || Ack_o !== 8'h02) begin
      errors++;
      $display("FAIL t6_grant: grant=%h sab=%b ack=%h, want 02/1/02", Grant_o, SAB_o, Ack_o);
    end
    Enable_i = 1'b0;
    for (int j = 1; j < 4; j++) begin
      tick();
      checks++;
      if (Ack_o !== 8'h02) begin
        errors++;
        $display("FAIL t6_ack%0d: ack=%h, want 02", j, Ack_o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Grant_o !== 8'h00 || Busy_o !== 1'b0 || Valid_o !== 1'b0) begin
        errors++;
        $display("FAIL t6_stay%0d: grant=%h busy=%b valid=%b, want 00/0/0", i, Grant_o, Busy_o, Valid_o);
      end
    end
  endtask

  initial begin
    Reset_n_i = 1'b0; Enable_i = 1'b0; Req_i = 8'h00; Ready_i = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_req_drop();
    test_mid_reset();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
